// File: rtl/mul_sched.sv
// Round-robin scheduler and shift-and-add sequencer that lets two clients share one W-bit multiplier.
// Optional early termination on an exhausted multiplier is enabled by defining MUL_SCHED_EARLY_EXIT_EN.
module mul_sched #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           busy,
  output logic           res_valid,
  output logic           res_id,
  output logic [2*W-1:0] res
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_id;
  logic             r_last;
  logic [2*W-1:0]   r_res;
  logic             r_resId;

  logic             w_grant;
  logic             w_pick1;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [2*W-1:0]   w_accNext;
  logic [W-1:0]     w_mplierNext;
  logic             w_lastStep;

  // On a tie the requester that was not served last wins; reset leaves r_last=1 so req0 wins first.
  assign w_pick1 = req1 && (!req0 || !r_last);
  assign w_grant = (r_state == IDLE) && !rst && (req0 || req1);
  assign gnt0    = w_grant && !w_pick1;
  assign gnt1    = w_grant && w_pick1;
  assign w_a     = w_pick1 ? a1 : a0;
  assign w_b     = w_pick1 ? b1 : b0;

  assign w_accNext    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplierNext = r_mplier >> 1;

`ifdef MUL_SCHED_EARLY_EXIT_EN
  assign w_lastStep = (w_mplierNext == '0) || (r_cnt == CW'(W - 1));
`else
  assign w_lastStep = (r_cnt == CW'(W - 1));
`endif

  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == DONE);
  assign res_id    = r_resId;
  assign res       = r_res;

  // Sequencer: capture on grant, one multiplier bit per CALC cycle, publish the product in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_id     <= 1'b0;
      r_last   <= 1'b1;
      r_res    <= '0;
      r_resId  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, w_a};
            r_mplier <= w_b;
            r_id     <= w_pick1;
            r_cnt    <= '0;
            r_last   <= w_pick1;
`ifdef MUL_SCHED_EARLY_EXIT_EN
            if (w_b == '0) begin
              r_res   <= '0;
              r_resId <= w_pick1;
              r_state <= DONE;
            end else begin
              r_state <= CALC;
            end
`else
            r_state  <= CALC;
`endif
          end
        end
        CALC: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplierNext;
          r_cnt    <= r_cnt + CW'(1);
          if (w_lastStep) begin
            r_res   <= w_accNext;
            r_resId <= r_id;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: vector table, arbitration sequences, reset abort and random operations.
// Expected products come from plain multiplication; expected latency from the grant-to-result timing rule.
module tb_mul_sched;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, busy, res_valid, res_id;
  logic [2*W-1:0] res;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    bit         id;
    logic [3:0] a;
    logic [3:0] b;
    int         expRes;
  } vec_t;

  vec_t vecs[8];

  mul_sched #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .res_valid(res_valid), .res_id(res_id), .res(res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Grants must be mutually exclusive on every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (gnt0 && gnt1) begin
        errors++;
        $display("[TB] FAIL exclusiveGrant: gnt0=%0b gnt1=%0b required not both", gnt0, gnt1);
      end
    end
  end

  // Cycles from grant to result pulse.
  function automatic int expLatency(input logic [W-1:0] b);
`ifdef MUL_SCHED_EARLY_EXIT_EN
    int k = 0;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return 1 + k;
`else
    return W + 1;
`endif
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; req0 = 1'b1; end
  endtask

  task automatic waitGrant(output bit ok, output bit who, output int t);
    ok = 0; who = 0; t = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        ok = 1; who = gnt1; t = cyc;
        break;
      end
    end
  endtask

  task automatic waitValid(output bit ok, output int t, output bit busyOk);
    ok = 0; t = 0; busyOk = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busyOk = 0;
      if (res_valid === 1'b1) begin
        ok = 1; t = cyc;
        break;
      end
    end
  endtask

  task automatic runOp(input string name, input bit id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int expRes);
    bit ok, who, busyOk;
    int tg, tv;
    applyStimulus(id, a, b);
    waitGrant(ok, who, tg);
    checkOutput({name, ".grant"}, ok, 1);
    if (!ok) begin
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    checkOutput({name, ".grantId"}, who, id);
    checkOutput({name, ".busyAtGrant"}, busy, 0);
    @(posedge clk);
    #1;
    if (id) req1 = 1'b0; else req0 = 1'b0;
    waitValid(ok, tv, busyOk);
    checkOutput({name, ".valid"}, ok, 1);
    if (!ok) return;
    checkOutput({name, ".latency"}, tv - tg, expLatency(b));
    checkOutput({name, ".res"}, res, expRes);
    checkOutput({name, ".resId"}, res_id, id);
    checkOutput({name, ".busyDuringOp"}, busyOk, 1);
    @(negedge clk);
    checkOutput({name, ".idleAfter"}, busy, 0);
    checkOutput({name, ".validPulse"}, res_valid, 0);
    checkOutput({name, ".resHeld"}, res, expRes);
  endtask

  initial begin
    bit ok, who, busyOk;
    int tg, tv, tPrev;
    logic [W-1:0] ra, rb;
    bit rid;

    vecs[0] = '{"v3x5",   1'b0, 4'd3,  4'd5,  15};
    vecs[1] = '{"v0x9",   1'b1, 4'd0,  4'd9,  0};
    vecs[2] = '{"v15x15", 1'b0, 4'd15, 4'd15, 225};
    vecs[3] = '{"v6x2",   1'b0, 4'd6,  4'd2,  12};
    vecs[4] = '{"v1x0",   1'b0, 4'd1,  4'd0,  0};
    vecs[5] = '{"v15x1",  1'b1, 4'd15, 4'd1,  15};
    vecs[6] = '{"v8x8",   1'b1, 4'd8,  4'd8,  64};
    vecs[7] = '{"v7x13",  1'b1, 4'd7,  4'd13, 91};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.gnt0", gnt0, 0);
    checkOutput("rst.gnt1", gnt1, 0);
    checkOutput("rst.resValid", res_valid, 0);
    checkOutput("rst.res", res, 0);
    checkOutput("rst.resId", res_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Simultaneous first requests: req0 wins, req1 waits and is served right after.
    @(posedge clk);
    #1;
    a0 = 4'd15; b0 = 4'd15; a1 = 4'd7; b1 = 4'd2;
    req0 = 1'b1; req1 = 1'b1;
    waitGrant(ok, who, tg);
    checkOutput("tie.firstGrant", ok, 1);
    checkOutput("tie.firstId", who, 0);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    waitValid(ok, tv, busyOk);
    checkOutput("tie.valid0", ok, 1);
    checkOutput("tie.lat0", tv - tg, expLatency(4'd15));
    checkOutput("tie.res0", res, 225);
    checkOutput("tie.id0", res_id, 0);
    tPrev = tg;
    waitGrant(ok, who, tg);
    checkOutput("tie.secondGrant", ok, 1);
    checkOutput("tie.secondId", who, 1);
    checkOutput("tie.secondGrantCycle", tg - tPrev, expLatency(4'd15) + 1);
    @(posedge clk);
    #1;
    req1 = 1'b0;
    waitValid(ok, tv, busyOk);
    checkOutput("tie.valid1", ok, 1);
    checkOutput("tie.lat1", tv - tg, expLatency(4'd2));
    checkOutput("tie.res1", res, 14);
    checkOutput("tie.id1", res_id, 1);

    // Both requests held: grants alternate, spaced by a full operation.
    @(posedge clk);
    #1;
    a0 = 4'd3; b0 = 4'd15; a1 = 4'd5; b1 = 4'd9;
    req0 = 1'b1; req1 = 1'b1;
    tPrev = 0;
    for (int i = 0; i < 4; i++) begin
      waitGrant(ok, who, tg);
      checkOutput("alt.grant", ok, 1);
      checkOutput("alt.order", who, i % 2);
      if (i > 0) checkOutput("alt.spacing", tg - tPrev, W + 2);
      tPrev = tg;
      if (i == 3) begin
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
      end
      waitValid(ok, tv, busyOk);
      checkOutput("alt.valid", ok, 1);
      checkOutput("alt.res", res, (i % 2 == 0) ? 45 : 45);
      checkOutput("alt.resId", res_id, i % 2);
    end
    @(negedge clk);

    foreach (vecs[i]) runOp(vecs[i].name, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].expRes);

    // Reset in the middle of a 9x9 discards it; a later 9x9 on requester 1 completes.
    applyStimulus(0, 4'd9, 4'd9);
    waitGrant(ok, who, tg);
    checkOutput("abort.grant", ok, 1);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("abort.busyBefore", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.resValid", res_valid, 0);
    checkOutput("abort.res", res, 0);
    checkOutput("abort.resId", res_id, 0);
    checkOutput("abort.gnt", {gnt0, gnt1}, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (res_valid === 1'b1) seen++;
      end
      checkOutput("abort.noValid", seen, 0);
    end
    runOp("post9x9", 1, 4'd9, 4'd9, 81);

    // Random single operations against plain multiplication.
    for (int n = 0; n < 24; n++) begin
      rid = 1'($urandom_range(0, 1));
      ra  = W'($urandom);
      rb  = W'($urandom);
      runOp("rand", rid, ra, rb, int'(ra) * int'(rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
# mul_sched

Two-requester scheduler and sequencer for the shared 4-bit unsigned multiplier. It arbitrates round-robin between two request ports and captures the winner's operands. It then runs a shift-and-add sequence, one multiplier bit per cycle, and returns the 8-bit product tagged with the requester id. It sits between the ALU operation decoder and a second client (address/scale logic), so both can use one multiply resource.

## Interface
Parameters:
- W, default 4: operand width. Product width is 2*W; the iteration count is W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  requester 0 request; level; held until granted
- a0, b0  in  W each  requester 0 multiplicand and multiplier
- req1  in  1  requester 1 request; level; held until granted
- a1, b1  in  W each  requester 1 multiplicand and multiplier
- gnt0, gnt1  out  1 each  one-cycle grant; operands are captured on the clock edge that ends this cycle
- busy  out  1  high in every state except IDLE
- res_valid  out  1  one-cycle pulse; product valid
- res_id  out  1  requester that owns the result (0 or 1)
- res  out  2*W  unsigned product

## Operation
- States are IDLE, CALC and DONE.
- **IDLE**
  - If no request is present, stay in IDLE.
  - If exactly one request is present, grant it.
  - If both are present, grant the requester that was not granted last. The pointer `last` resets to 1, so req0 wins the first tie.
  - Grant logic is combinational from req and state. gntX is high only in IDLE and never for both requesters.
- **On grant edge**
  - Load: acc=0, mcand={W zeros, aX}, mplier=bX, id=X, cnt=0, last=X.
  - Go to CALC.
- **CALC** (one bit per cycle)
  - If mplier[0]=1, then acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - After the cycle with cnt=W-1, go to DONE.
- **Arithmetic**
  - acc is 2*W bits. All arithmetic is unsigned.
  - The sum can never overflow 2*W bits: the maximum is (2^W-1)^2.
- **DONE**
  - res_valid=1, res=acc, res_id=id.
  - Go to IDLE next cycle.
  - res and res_id hold their values until the next DONE.
- **Request timing**
  - A requester drops reqX after it sees gntX high.
  - A reqX still high in the cycle after the grant is treated as a new request.
- **Reset** (any time, including mid-CALC)
  - State=IDLE, acc=0, res=0, res_id=0, res_valid=0, busy=0, gnt0=gnt1=0, last=1, cnt=0.
  - An in-flight operation is discarded and produces no res_valid.

## Timing
- Grant in cycle T.
- CALC occupies T+1..T+W.
- res_valid is high in cycle T+W+1. For W=4 that is T+5.
- IDLE in T+W+2. The earliest next grant is T+W+2, i.e. T+6 for W=4.
- Throughput is one product per W+2 cycles with continuous requests.
- A request arriving while busy waits and is never dropped.
- Both requests continuously high: grants alternate 0,1,0,1…

## Configuration
- The macro is `MUL_SCHED_EARLY_EXIT_EN`.
- **Defined:**
  - CALC exits to DONE after the first cycle in which the shifted mplier becomes 0.
  - If the captured bX=0, IDLE goes directly to DONE with res=0.
  - Latency: res_valid in cycle T+1+k, where k = index of the highest set bit of bX, plus 1 (k=0 when bX=0).
- **Undefined:**
  - The fixed W-cycle CALC applies for every operand pair.
  - Latency is always T+W+1.

## Test plan
- Single req0, a0=3, b0=5 granted at T → res_valid at T+5, res=15, res_id=0, busy high T+1..T+5.
- req0 and req1 together after reset; a0=15,b0=15 and a1=7,b1=2 → gnt0 first; res=225 id=0; gnt1 at T+6; res=14 id=1 at T+11.
- Both requests held high for four operations → grant order 0,1,0,1; gnt0 and gnt1 are never simultaneous.
- a1=0, b1=9 → res=0 at T+5. Run without the macro.
- Same run with `MUL_SCHED_EARLY_EXIT_EN`:
  - b0=0 → res_valid at T+1, res=0.
  - b0=2, a0=6 → res_valid at T+3, res=12.
- rst asserted mid-CALC during a 9×9 operation → all outputs 0 immediately, no res_valid. The next req1 after reset is granted and 9×9=81 completes normally.
